// File: rtl/cordic_sequencer.sv
// ---------------------------------------------------------------------------
// cordic_sequencer
//   Control FSM for an iterative CORDIC datapath. Accepts a one-cycle start
//   pulse with operands and a gain-compensation enable, then drives the core
//   through LOAD, N_ITER micro-rotations and an optional COMP step. It then
//   registers the core result and pulses done.
//
// Ports
//   clk           : rising-edge clock
//   reset         : asynchronous active-low reset
//   start         : one-cycle request pulse (accepted only when idle)
//   x_input       : signed X operand, sampled on accepted start
//   y_input       : signed Y operand, sampled on accepted start
//   K_mode        : gain-compensation enable, sampled on accepted start
//   core_x/core_y : combinational view of the core's X/Y state
//   core_load     : core loads op_x/op_y this cycle
//   op_x/op_y     : latched operands presented to the core
//   core_iter_en  : core performs one micro-rotation this cycle
//   iter_idx      : shift amount / atan LUT index of the current iteration
//   core_comp_en  : core applies the gain-compensation multiply this cycle
//   busy          : operation in progress (LOAD through DONE)
//   done          : one-cycle completion pulse
//   result_x/_y   : registered result, held until the next completion
//   overrun       : sticky; a start arrived while not idle
// ---------------------------------------------------------------------------
module cordic_sequencer #(
  parameter int WIDTH  = 8,
  parameter int N_ITER = 8,
  parameter int IDX_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_input,
  input  logic signed [WIDTH-1:0] y_input,
  input  logic                    K_mode,
  input  logic signed [WIDTH-1:0] core_x,
  input  logic signed [WIDTH-1:0] core_y,
  output logic                    core_load,
  output logic signed [WIDTH-1:0] op_x,
  output logic signed [WIDTH-1:0] op_y,
  output logic                    core_iter_en,
  output logic [IDX_W-1:0]        iter_idx,
  output logic                    core_comp_en,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result_x,
  output logic signed [WIDTH-1:0] result_y,
  output logic                    overrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_COMP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITER - 1);

  logic [2:0]              state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    k_lat_q, k_lat_d;
  logic signed [WIDTH-1:0] op_x_q, op_x_d;
  logic signed [WIDTH-1:0] op_y_q, op_y_d;
  logic signed [WIDTH-1:0] result_x_q, result_x_d;
  logic signed [WIDTH-1:0] result_y_q, result_y_d;
  logic                    overrun_q, overrun_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    core_load_q, core_load_d;
  logic                    core_iter_en_q, core_iter_en_d;
  logic                    core_comp_en_q, core_comp_en_d;
  logic                    capture_s;

  // Next-state, operand latch, iteration counter and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_lat_d   = k_lat_q;
    op_x_d    = op_x_q;
    op_y_d    = op_y_q;
    capture_s = 1'b0;
    // A start outside IDLE is dropped and recorded; an accepted one clears it.
    overrun_d = (state_q == S_IDLE) ? (overrun_q & ~start) : (overrun_q | start);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          op_x_d  = x_input;
          op_y_d  = y_input;
          k_lat_d = K_mode;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_ITER;
        cnt_d   = {IDX_W{1'b0}};
      end
      S_ITER: begin
        if (cnt_q == LAST_IDX) begin
          // Counter parks at zero so iter_idx reads 0 outside ITER.
          cnt_d = {IDX_W{1'b0}};
          if (k_lat_q) begin
            state_d = S_COMP;
          end else begin
            state_d   = S_DONE;
            capture_s = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + IDX_W'(1'b1);
        end
      end
      S_COMP: begin
        state_d   = S_DONE;
        capture_s = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {IDX_W{1'b0}};
      end
    endcase

    result_x_d = capture_s ? core_x : result_x_q;
    result_y_d = capture_s ? core_y : result_y_q;

    // Strobes are decoded from the next state so they are registered
    // alongside it and line up with the state they belong to.
    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);
    core_load_d    = (state_d == S_LOAD);
    core_iter_en_d = (state_d == S_ITER);
    core_comp_en_d = (state_d == S_COMP);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= {IDX_W{1'b0}};
      k_lat_q        <= 1'b0;
      op_x_q         <= {WIDTH{1'b0}};
      op_y_q         <= {WIDTH{1'b0}};
      result_x_q     <= {WIDTH{1'b0}};
      result_y_q     <= {WIDTH{1'b0}};
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      core_load_q    <= 1'b0;
      core_iter_en_q <= 1'b0;
      core_comp_en_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      k_lat_q        <= k_lat_d;
      op_x_q         <= op_x_d;
      op_y_q         <= op_y_d;
      result_x_q     <= result_x_d;
      result_y_q     <= result_y_d;
      overrun_q      <= overrun_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      core_load_q    <= core_load_d;
      core_iter_en_q <= core_iter_en_d;
      core_comp_en_q <= core_comp_en_d;
    end
  end

  assign core_load    = core_load_q;
  assign op_x         = op_x_q;
  assign op_y         = op_y_q;
  assign core_iter_en = core_iter_en_q;
  assign iter_idx     = cnt_q;
  assign core_comp_en = core_comp_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result_x     = result_x_q;
  assign result_y     = result_y_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cordic_sequencer
//   Self-checking bench for cordic_sequencer. A behavioural CORDIC core
//   answers the sequencer's strobes. Expected results come from a reference
//   that simply loops N rotations (+ optional compensation) over the operands.
//   Expected strobe timing is derived from the start-relative cycle number.
// ---------------------------------------------------------------------------
module tb_cordic_sequencer;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int IW = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic                K_mode = 1'b0;
  logic signed [W-1:0] x_input = 8'sd0;
  logic signed [W-1:0] y_input = 8'sd0;
  logic signed [W-1:0] core_x, core_y;
  logic                core_load, core_iter_en, core_comp_en, busy, done, overrun;
  logic signed [W-1:0] op_x, op_y, result_x, result_y;
  logic [IW-1:0]       iter_idx;

  int                  n_cmp = 0;
  int                  n_err = 0;
  logic                exp_ovr = 1'b0;
  logic signed [W-1:0] exp_rx = 8'sd0;
  logic signed [W-1:0] exp_ry = 8'sd0;

  cordic_sequencer #(.WIDTH(W), .N_ITER(N), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_input(x_input), .y_input(y_input), .K_mode(K_mode),
    .core_x(core_x), .core_y(core_y),
    .core_load(core_load), .op_x(op_x), .op_y(op_y),
    .core_iter_en(core_iter_en), .iter_idx(iter_idx),
    .core_comp_en(core_comp_en), .busy(busy), .done(done),
    .result_x(result_x), .result_y(result_y), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // One vectoring-style micro-rotation on 8-bit wrapping values.
  function automatic logic [2*W-1:0] rot_step(input logic signed [W-1:0] x,
                                              input logic signed [W-1:0] y,
                                              input int i);
    logic signed [W-1:0] nx, ny;
    if (y >= 0) begin
      nx = x + (y >>> i);
      ny = y - (x >>> i);
    end else begin
      nx = x - (y >>> i);
      ny = y + (x >>> i);
    end
    return {nx, ny};
  endfunction

  // Approximate gain compensation: v * 3/4.
  function automatic logic [2*W-1:0] comp_step(input logic signed [W-1:0] x,
                                               input logic signed [W-1:0] y);
    logic signed [W-1:0] nx, ny;
    nx = x - (x >>> 2);
    ny = y - (y >>> 2);
    return {nx, ny};
  endfunction

  // Whole-operation reference: N rotations then optional compensation.
  function automatic logic [2*W-1:0] ref_op(input logic signed [W-1:0] x0,
                                            input logic signed [W-1:0] y0,
                                            input logic k);
    logic signed [W-1:0] x, y;
    x = x0;
    y = y0;
    for (int i = 0; i < N; i++) {x, y} = rot_step(x, y, i);
    if (k) {x, y} = comp_step(x, y);
    return {x, y};
  endfunction

  // Behavioural core: core_x/core_y show the state after this cycle's action.
  logic signed [W-1:0] cx_r = 8'sd0;
  logic signed [W-1:0] cy_r = 8'sd0;
  always_comb begin
    core_x = cx_r;
    core_y = cy_r;
    if (core_load) begin
      core_x = op_x;
      core_y = op_y;
    end else if (core_iter_en) begin
      {core_x, core_y} = rot_step(cx_r, cy_r, int'(iter_idx));
    end else if (core_comp_en) begin
      {core_x, core_y} = comp_step(cx_r, cy_r);
    end
  end
  always @(posedge clk) begin
    cx_r <= core_x;
    cy_r <= core_y;
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({core_load, core_iter_en, core_comp_en, busy, done, overrun} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl got %b exp 000000",
               {core_load, core_iter_en, core_comp_en, busy, done, overrun});
    end
    n_cmp++;
    if ({op_x, op_y, result_x, result_y, iter_idx} !== {(4*W+IW){1'b0}}) begin
      n_err++;
      $display("FAIL reset_data got op %0d/%0d res %0d/%0d idx %0d exp all 0",
               op_x, op_y, result_x, result_y, iter_idx);
    end
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({core_load, core_iter_en, core_comp_en, busy, done} !== 5'b0) begin
        n_err++;
        $display("FAIL idle_strobes c=%0d got %b exp 00000", c,
                 {core_load, core_iter_en, core_comp_en, busy, done});
      end
    end
  endtask

  // Runs one operation from a negedge. ovr_at (1..done cycle) injects a
  // dropped start with x=-50 in that cycle; 0 disables. tail = idle cycles
  // checked after done; returns at a negedge with start low.
  task automatic test_operation(input logic signed [W-1:0] x,
                                input logic signed [W-1:0] y,
                                input logic k, input int ovr_at,
                                input int tail, input string name);
    logic [2*W-1:0] r;
    logic [IW-1:0]  e_idx;
    int             done_c;
    done_c = k ? N + 3 : N + 2;
    r = ref_op(x, y, k);
    start = 1'b1;
    x_input = x;
    y_input = y;
    K_mode = k;
    @(posedge clk);
    exp_ovr = 1'b0;
    for (int c = 1; c <= done_c + tail; c++) begin
      @(negedge clk);
      start = 1'b0;
      x_input = W'($urandom);
      y_input = W'($urandom);
      K_mode = 1'($urandom);
      if (c == done_c) begin
        exp_rx = r[2*W-1:W];
        exp_ry = r[W-1:0];
      end
      e_idx = (c >= 2 && c <= N + 1) ? IW'(c - 2) : {IW{1'b0}};
      n_cmp++;
      if (core_load !== (c == 1)) begin
        n_err++;
        $display("FAIL %s core_load c=%0d got %b exp %b", name, c, core_load, (c == 1));
      end
      n_cmp++;
      if (core_iter_en !== (c >= 2 && c <= N + 1) || iter_idx !== e_idx) begin
        n_err++;
        $display("FAIL %s iter c=%0d got en %b idx %0d exp en %b idx %0d", name, c,
                 core_iter_en, iter_idx, (c >= 2 && c <= N + 1), e_idx);
      end
      n_cmp++;
      if (core_comp_en !== (k && c == N + 2)) begin
        n_err++;
        $display("FAIL %s comp_en c=%0d got %b exp %b", name, c, core_comp_en,
                 (k && c == N + 2));
      end
      n_cmp++;
      if (done !== (c == done_c) || busy !== (c <= done_c)) begin
        n_err++;
        $display("FAIL %s done_busy c=%0d got %b%b exp %b%b", name, c, done, busy,
                 (c == done_c), (c <= done_c));
      end
      n_cmp++;
      if (overrun !== exp_ovr) begin
        n_err++;
        $display("FAIL %s overrun c=%0d got %b exp %b", name, c, overrun, exp_ovr);
      end
      n_cmp++;
      if (result_x !== exp_rx || result_y !== exp_ry) begin
        n_err++;
        $display("FAIL %s result c=%0d got %0d/%0d exp %0d/%0d", name, c,
                 result_x, result_y, exp_rx, exp_ry);
      end
      if (c == ovr_at) begin
        start = 1'b1;
        x_input = -8'sd50;
        exp_ovr = 1'b1;
      end
    end
  endtask

  task automatic test_random();
    logic            k;
    int              ovr, tail;
    logic signed [W-1:0] x, y;
    for (int i = 0; i < 8; i++) begin
      k = 1'($urandom_range(0, 1));
      ovr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, k ? N + 3 : N + 2)) : 0;
      tail = int'($urandom_range(1, 3));
      x = W'($urandom);
      y = W'($urandom);
      test_operation(x, y, k, ovr, tail, "random");
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    x_input = 8'sd77;
    y_input = -8'sd20;
    K_mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (iter_idx !== 3'd4 || core_iter_en !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre got idx %0d en %b exp idx 4 en 1", iter_idx, core_iter_en);
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if ({core_load, core_iter_en, core_comp_en, busy, done, overrun, iter_idx} !== 9'b0 ||
        {op_x, op_y, result_x, result_y} !== {(4*W){1'b0}}) begin
      n_err++;
      $display("FAIL arst_clear got ctl %b idx %0d op %0d/%0d res %0d/%0d exp all 0",
               {core_load, core_iter_en, core_comp_en, busy, done, overrun},
               iter_idx, op_x, op_y, result_x, result_y);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_ovr = 1'b0;
    exp_rx = 8'sd0;
    exp_ry = 8'sd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || result_x !== 8'sd0) begin
        n_err++;
        $display("FAIL arst_quiet c=%0d got done %b busy %b rx %0d exp 0 0 0", c,
                 done, busy, result_x);
      end
    end
    test_operation(8'sd77, -8'sd20, 1'b0, 0, 2, "arst_fresh");
  endtask

  initial begin
    test_reset();
    test_operation(8'sd100, 8'sd0, 1'b0, 0, 2, "basic");
    test_operation(8'sd100, 8'sd0, 1'b1, 0, 2, "k_on");
    test_operation(8'sd100, 8'sd0, 1'b0, 5, 2, "overrun");
    test_operation(-8'sd37, 8'sd64, 1'b0, 0, 1, "clear_ovr");
    test_operation(8'sd12, -8'sd90, 1'b1, 0, 1, "b2b_a");
    test_operation(8'sd45, 8'sd45, 1'b0, N + 2, 1, "b2b_drop");
    test_operation(-8'sd128, 8'sd127, 1'b1, 0, 2, "b2b_after");
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
